awg_param_ctrl: RTL and testbench
=================================

Name: awg_param_ctrl

Overview:
- Front-panel control stage directly upstream of the signal generator.
- Debounces four active-low push keys and runs a field-edit state machine.
- Drives the registered waveform select, frequency, amplitude and phase words consumed by the generator: state, state_freq, state_amp, state_phase.

Parameters:
- DB_CYCLES, 1000000: consecutive stable samples required to accept a key level change (20 ms at 50 MHz).
- REPEAT_DELAY, 25000000: hold time on up/dn before the first auto-repeat pulse.
- REPEAT_PERIOD, 5000000: interval between subsequent auto-repeat pulses.
- FREQ_MAX, 4095: upper saturation bound of state_freq.
- FREQ_DEF, 1: reset value of state_freq.

Ports:
- clk  in  1  system clock; the DAC clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- key_wave_n  in  1  raw key, active-low: step waveform.
- key_sel_n  in  1  raw key, active-low: step edited field.
- key_up_n  in  1  raw key, active-low: increment edited field.
- key_dn_n  in  1  raw key, active-low: decrement edited field.
- state  out  3  waveform code to generator.
- state_freq  out  12  frequency word.
- state_amp  out  3  amplitude step.
- state_phase  out  8  phase offset.
- edit_field  out  2  currently edited field (for LED indication).

Behaviour:
- Reset values (async on rst_n=0): state=0, state_freq=FREQ_DEF, state_amp=7, state_phase=0, edit_field=0. All debounce and repeat counters cleared; debounced levels = released (1).
- Key path, per key:
  - 2-FF synchronizer, then a debounce counter.
  - Counter increments while the synced value differs from the debounced level and clears when they match.
  - On reaching DB_CYCLES-1, the debounced level flips and the counter clears.
  - Press pulse = 1-cycle strobe on a debounced 1->0 transition. Release produces no pulse.
- Auto-repeat (up/dn only):
  - While the debounced level is pressed, a hold counter runs.
  - First repeat pulse when the counter reaches REPEAT_DELAY; then one every REPEAT_PERIOD.
  - Counter clears on release.
- Latency: raw key edge -> press pulse = 2 + DB_CYCLES cycles. Pulse -> registered output change = 1 cycle.
- Waveform sequence on wave pulse: 0 -> 1 -> 2 -> 3 -> 4 -> 7 -> 0. Codes 5 and 6 are never produced. If state holds 5 or 6, the next pulse goes to 0.
- Edit-field FSM: F_FREQ(0) -> F_AMP(1) -> F_PHASE(2) -> F_FREQ on sel pulse. Code 3 is unreachable; if it occurs, return to F_FREQ on the next cycle.
- Adjust rules (inc on up pulse, dec on dn pulse):
  - F_FREQ: saturate in [1, FREQ_MAX]; 0 is never output.
  - F_AMP: saturate in [0, 7].
  - F_PHASE: wraps modulo 256 (255+1=0, 0-1=255).
- Simultaneous events in the same cycle:
  - up and dn together: no change.
  - sel with up/dn: the adjust applies to the old field, and the field advances at the same edge.
  - wave with any other pulse: both take effect independently.
- Reset mid-operation: all outputs return to reset values immediately. A key held through reset deassertion is seen as a fresh press after 2+DB_CYCLES cycles.
- All outputs are registered. There is no combinational path from keys to outputs.

Decomposition:
- Package awg_pkg holds:
  - waveform codes: WAVE_SAW=0, WAVE_TRI=1, WAVE_SQR=2, WAVE_SIN=3, WAVE_RAND=4, WAVE_OFF=7;
  - field codes: F_FREQ, F_AMP, F_PHASE;
  - amplitude limits: AMP_MAX=7, AMP_DEF=7.
- Sub-module key_debounce, instantiated four times: synchronizer, debounce counter, press pulse, and optional repeat pulse gated by a REPEAT_EN parameter (enabled for up/dn only).

Test Plan (DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
1. Reset, then 6 clean wave presses -> state walks 1, 2, 3, 4, 7, 0. Each change occurs exactly 7 cycles after the raw key falls.
2. Bounce key_up_n with 1-3 cycle glitches for 30 cycles, then hold low 10 cycles -> no output change during the glitches; state_freq 1->2 exactly once.
3. In F_FREQ, hold dn from freq=1 -> stays 1. Preload freq=4094, press up 3 times -> 4095 and stays.
4. Select F_PHASE (2 sel presses), phase=0, press dn -> 255; press up -> 0. edit_field=2 throughout.
5. In F_AMP, hold up for 60 cycles after debounce from amp=3 -> pulses at debounce, +20, +28, +36, +44, +52; amp saturates at 7.
6. Up, dn and sel pulses in the same cycle in F_FREQ at freq=10 -> freq stays 10 and edit_field becomes 1. Assert rst_n low mid-hold -> outputs equal reset values within the same cycle.

Source files
------------

// File: rtl/awg_pkg.sv
// awg_pkg: shared codes and limits for the AWG front-panel control stage.
//   Waveform codes driven on state, edit-field encoding, amplitude limits,
//   and the waveform stepping order used on each wave key press.
package awg_pkg;

    localparam logic [2:0] WAVE_SAW  = 3'd0;
    localparam logic [2:0] WAVE_TRI  = 3'd1;
    localparam logic [2:0] WAVE_SQR  = 3'd2;
    localparam logic [2:0] WAVE_SIN  = 3'd3;
    localparam logic [2:0] WAVE_RAND = 3'd4;
    localparam logic [2:0] WAVE_OFF  = 3'd7;

    typedef enum logic [1:0] {
        F_FREQ  = 2'd0,
        F_AMP   = 2'd1,
        F_PHASE = 2'd2
    } field_t;

    localparam logic [2:0] AMP_MAX = 3'd7;
    localparam logic [2:0] AMP_DEF = 3'd7;

    // Codes 5 and 6 are not part of the cycle; they fall back to sawtooth.
    function automatic logic [2:0] next_wave(input logic [2:0] w);
        return w == WAVE_SAW  ? WAVE_TRI  :
               w == WAVE_TRI  ? WAVE_SQR  :
               w == WAVE_SQR  ? WAVE_SIN  :
               w == WAVE_SIN  ? WAVE_RAND :
               w == WAVE_RAND ? WAVE_OFF  : WAVE_SAW;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces one active-low push key.
//   clk, rst_n : clock and async active-low reset
//   key_n      : raw key level, low = pressed
//   pulse      : one-cycle strobe on an accepted press, plus auto-repeat
//                strobes while held when REPEAT_EN is set
module key_debounce
    import awg_pkg::*;
#(
    parameter int DB_CYCLES     = 1000000,
    parameter bit REPEAT_EN     = 1'b0,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pulse
);

    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_DELAY + 1);

    logic          sync1, sync2, level, press, rep;
    logic [DW-1:0] cnt;
    logic [RW-1:0] hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level)
                cnt <= '0;
            else if (cnt == DW'(DB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else
                cnt <= cnt + DW'(1);
        end
    end

    // After the first repeat the counter is rewound by one period, so the
    // same terminal compare produces every later repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
            rep  <= 1'b0;
        end else if (!REPEAT_EN || level) begin
            hold <= '0;
            rep  <= 1'b0;
        end else if (hold == RW'(REPEAT_DELAY - 1)) begin
            hold <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
            rep  <= 1'b1;
        end else begin
            hold <= hold + RW'(1);
            rep  <= 1'b0;
        end
    end

    assign pulse = press | rep;

endmodule

// File: rtl/awg_param_ctrl.sv
// awg_param_ctrl: front-panel key handling and parameter registers for the AWG.
//   clk, rst_n            : DAC-domain clock, async active-low reset
//   key_wave_n/key_sel_n  : raw keys stepping waveform / edited field
//   key_up_n/key_dn_n     : raw keys adjusting the edited field (auto-repeat)
//   state                 : waveform code
//   state_freq            : frequency word, saturating in [1, FREQ_MAX]
//   state_amp             : amplitude step, saturating in [0, AMP_MAX]
//   state_phase           : phase offset, wrapping modulo 256
//   edit_field            : field currently adjusted by up/dn
module awg_param_ctrl
    import awg_pkg::*;
#(
    parameter int DB_CYCLES     = 1000000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int FREQ_MAX      = 4095,
    parameter int FREQ_DEF      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_wave_n,
    input  logic        key_sel_n,
    input  logic        key_up_n,
    input  logic        key_dn_n,
    output logic [2:0]  state,
    output logic [11:0] state_freq,
    output logic [2:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic [1:0]  edit_field
);

    localparam logic [11:0] FMAX = 12'(FREQ_MAX);
    localparam logic [11:0] FDEF = 12'(FREQ_DEF);

    logic   wave_p, sel_p, up_p, dn_p, inc, dec;
    field_t field;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_wave (
        .clk(clk), .rst_n(rst_n), .key_n(key_wave_n), .pulse(wave_p)
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_sel (
        .clk(clk), .rst_n(rst_n), .key_n(key_sel_n), .pulse(sel_p)
    );
    key_debounce #(
        .DB_CYCLES(DB_CYCLES), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_up (
        .clk(clk), .rst_n(rst_n), .key_n(key_up_n), .pulse(up_p)
    );
    key_debounce #(
        .DB_CYCLES(DB_CYCLES), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_dn (
        .clk(clk), .rst_n(rst_n), .key_n(key_dn_n), .pulse(dn_p)
    );

    // Opposing adjust strobes in the same cycle cancel out.
    assign inc        = up_p & ~dn_p;
    assign dec        = dn_p & ~up_p;
    assign edit_field = field;

    // Adjusts look at the field before this edge, so a simultaneous sel
    // press lands its up/dn on the old field while the field advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAVE_SAW;
            state_freq  <= FDEF;
            state_amp   <= AMP_DEF;
            state_phase <= 8'd0;
            field       <= F_FREQ;
        end else begin
            if (wave_p)
                state <= next_wave(state);
            field <= field == F_FREQ  ? (sel_p ? F_AMP   : F_FREQ)  :
                     field == F_AMP   ? (sel_p ? F_PHASE : F_AMP)   :
                     field == F_PHASE && !sel_p ? F_PHASE : F_FREQ;
            if (field == F_FREQ && (inc || dec))
                state_freq <= inc ? (state_freq >= FMAX ? FMAX : state_freq + 12'd1)
                                  : (state_freq <= 12'd1 ? 12'd1 : state_freq - 12'd1);
            if (field == F_AMP && (inc || dec))
                state_amp <= inc ? (state_amp == AMP_MAX ? AMP_MAX : state_amp + 3'd1)
                                 : (state_amp == 3'd0 ? 3'd0 : state_amp - 3'd1);
            if (field == F_PHASE && (inc || dec))
                state_phase <= inc ? state_phase + 8'd1 : state_phase - 8'd1;
        end
    end

endmodule

// File: tb/tb_awg_param_ctrl.sv
// tb_awg_param_ctrl: self-checking bench for awg_param_ctrl with short debounce/repeat timing.
module tb_awg_param_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kw = 1'b1, ks = 1'b1, ku = 1'b1, kd = 1'b1;
    logic [2:0]  state;
    logic [11:0] state_freq;
    logic [2:0]  state_amp;
    logic [7:0]  state_phase;
    logic [1:0]  edit_field;

    awg_param_ctrl #(
        .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .FREQ_MAX(4095), .FREQ_DEF(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .key_wave_n(kw), .key_sel_n(ks), .key_up_n(ku), .key_dn_n(kd),
        .state(state), .state_freq(state_freq), .state_amp(state_amp),
        .state_phase(state_phase), .edit_field(edit_field)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int m_st, m_f, m_a, m_p, m_fd;
    int nxt_wave [8] = '{1, 2, 3, 4, 7, 0, 0, 0};

    typedef struct {
        logic [3:0] m;
        int         l;
        int         st, f, a, p, fd;
    } vec_t;
    vec_t vt [12];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input int st, input int f, input int a, input int p, input int fd);
        chk({tag, ".state"}, int'(state), st);
        chk({tag, ".freq"}, int'(state_freq), f);
        chk({tag, ".amp"}, int'(state_amp), a);
        chk({tag, ".phase"}, int'(state_phase), p);
        chk({tag, ".field"}, int'(edit_field), fd);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mask bits: 0 wave, 1 sel, 2 up, 3 dn
    task automatic drive(input logic [3:0] m);
        kw = ~m[0]; ks = ~m[1]; ku = ~m[2]; kd = ~m[3];
    endtask

    task automatic press(input logic [3:0] m, input int l);
        drive(m);
        cyc(l);
        drive(4'b0000);
        cyc(10);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'b0000);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    function automatic void m_adj(input int dir);
        if (dir == 0) return;
        if (m_fd == 0) m_f = (m_f + dir < 1) ? 1 : (m_f + dir > 4095) ? 4095 : m_f + dir;
        else if (m_fd == 1) m_a = (m_a + dir < 0) ? 0 : (m_a + dir > 7) ? 7 : m_a + dir;
        else m_p = (m_p + dir + 256) % 256;
    endfunction

    // A key held low for l raw cycles stays debounced-low for l cycles: one
    // press pulse, then repeats at RD, RD+RP, ... cycles into the hold.
    function automatic void m_op(input logic [3:0] m, input int l);
        int n, dir;
        n   = 1 + ((l >= RD) ? 1 + (l - RD) / RP : 0);
        dir = (m[2] && !m[3]) ? 1 : (m[3] && !m[2]) ? -1 : 0;
        if (m[0]) m_st = nxt_wave[m_st];
        m_adj(dir);
        if (m[1]) m_fd = (m_fd + 1) % 3;
        for (int i = 1; i < n; i++) m_adj(dir);
    endfunction

    initial begin
        int cp [9] = '{6, 7, 26, 27, 34, 35, 42, 43, 66};
        int cv [9] = '{3, 4, 4, 5, 5, 6, 6, 7, 7};
        int wexp [6] = '{1, 2, 3, 4, 7, 0};
        int prev, t, g;
        logic [3:0] rm;
        int rl;

        vt[0]  = '{4'b0001, 5,  1, 1, 7, 0,   0};
        vt[1]  = '{4'b0100, 5,  1, 2, 7, 0,   0};
        vt[2]  = '{4'b0010, 5,  1, 2, 7, 0,   1};
        vt[3]  = '{4'b1000, 5,  1, 2, 6, 0,   1};
        vt[4]  = '{4'b0110, 5,  1, 2, 7, 0,   2};
        vt[5]  = '{4'b1000, 5,  1, 2, 7, 255, 2};
        vt[6]  = '{4'b0100, 5,  1, 2, 7, 0,   2};
        vt[7]  = '{4'b0010, 5,  1, 2, 7, 0,   0};
        vt[8]  = '{4'b1100, 5,  1, 2, 7, 0,   0};
        vt[9]  = '{4'b0101, 5,  2, 3, 7, 0,   0};
        vt[10] = '{4'b0100, 24, 2, 5, 7, 0,   0};
        vt[11] = '{4'b1000, 24, 2, 3, 7, 0,   0};

        cyc(1);
        do_reset();
        chk_all("reset", 0, 1, 7, 0, 0);

        foreach (vt[i]) begin
            press(vt[i].m, vt[i].l);
            chk_all($sformatf("vec%0d", i), vt[i].st, vt[i].f, vt[i].a, vt[i].p, vt[i].fd);
        end

        // Wave walk with exact press-to-output latency
        do_reset();
        for (int i = 0; i < 6; i++) begin
            prev = int'(state);
            drive(4'b0001);
            cyc(6);
            chk($sformatf("wave%0d_early", i), int'(state), prev);
            cyc(1);
            chk($sformatf("wave%0d", i), int'(state), wexp[i]);
            drive(4'b0000);
            cyc(10);
        end

        // Bouncing up key: glitches of at most DB-1 cycles must be ignored
        t = 0;
        while (t < 30) begin
            g = int'($urandom_range(1, 3));
            ku = 1'b0;
            for (int k = 0; k < g; k++) begin cyc(1); chk("bounce_lo", int'(state_freq), 1); end
            ku = 1'b1;
            for (int k = 0; k < 3; k++) begin cyc(1); chk("bounce_hi", int'(state_freq), 1); end
            t += g + 3;
        end
        press(4'b0100, 10);
        chk("bounce_accept", int'(state_freq), 2);

        // Frequency saturation at both ends
        press(4'b1000, 5);
        chk("freq_to_min", int'(state_freq), 1);
        press(4'b1000, 40);
        chk("freq_hold_min", int'(state_freq), 1);
        press(4'b0100, 32800);
        chk("freq_sat_max", int'(state_freq), 4095);
        press(4'b1000, 5);
        chk("freq_4094", int'(state_freq), 4094);
        for (int i = 0; i < 3; i++) begin
            press(4'b0100, 5);
            chk($sformatf("freq_up%0d", i), int'(state_freq), 4095);
        end

        // Phase wrap in F_PHASE
        press(4'b0010, 5);
        chk("sel_amp", int'(edit_field), 1);
        press(4'b0010, 5);
        chk("sel_phase", int'(edit_field), 2);
        press(4'b1000, 5);
        chk("phase_dn", int'(state_phase), 255);
        chk("phase_dn_field", int'(edit_field), 2);
        press(4'b0100, 5);
        chk("phase_up", int'(state_phase), 0);
        chk("phase_up_field", int'(edit_field), 2);

        // Auto-repeat timing in F_AMP from amp=3
        press(4'b0010, 5);
        press(4'b0010, 5);
        chk("field_amp", int'(edit_field), 1);
        for (int i = 0; i < 4; i++) press(4'b1000, 5);
        chk("amp3", int'(state_amp), 3);
        drive(4'b0100);
        for (int c = 1; c <= 66; c++) begin
            cyc(1);
            for (int j = 0; j < 9; j++)
                if (cp[j] == c) chk($sformatf("rep_c%0d", c), int'(state_amp), cv[j]);
        end
        drive(4'b0000);
        cyc(10);

        // Simultaneous up/dn/sel, then reset mid-hold
        do_reset();
        press(4'b0100, 80);
        chk("freq10", int'(state_freq), 10);
        press(4'b1110, 5);
        chk("simul_freq", int'(state_freq), 10);
        chk("simul_field", int'(edit_field), 1);
        press(4'b0001, 5);
        press(4'b1000, 5);
        chk("pre_rst_amp", int'(state_amp), 6);
        drive(4'b0100);
        cyc(8);
        chk("held_amp", int'(state_amp), 7);
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 0, 1, 7, 0, 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(6);
        chk("held_thru_rst_early", int'(state_freq), 1);
        cyc(1);
        chk("held_thru_rst", int'(state_freq), 2);
        drive(4'b0000);
        cyc(10);

        // Randomized operations against the reference model
        do_reset();
        m_st = 0; m_f = 1; m_a = 7; m_p = 0; m_fd = 0;
        for (int i = 0; i < 40; i++) begin
            rm = 4'($urandom_range(1, 15));
            rl = ($urandom_range(0, 1) == 0) ? int'($urandom_range(5, 15))
                                             : RD + RP * int'($urandom_range(0, 4)) + int'($urandom_range(2, 6));
            press(rm, rl);
            m_op(rm, rl);
            chk_all($sformatf("rnd%0d", i), m_st, m_f, m_a, m_p, m_fd);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
